uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-byte front end for the instruction engine: samples the asynchronous UART line, recovers 8N1 frames (optionally 8E1), and presents each good byte as a one-cycle valid strobe with the data byte. It sits directly upstream of the instruction engine, whose byte-valid and byte inputs connect to `o_Rx_DV` and `o_Rx_Byte`. Malformed frames are reported on error strobes and never produce a valid strobe.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200); must be ≥ 4.
- `i_Clock` in 1: sole clock; all state on its rising edge.
- `i_Reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `i_Rx_Serial` in 1: raw UART line, asynchronous, idle high.
- `o_Rx_DV` out 1: one-cycle pulse; `o_Rx_Byte` is valid in that cycle.
- `o_Rx_Byte` out 8: last good byte; holds until the next `o_Rx_DV`.
- `o_Frame_Err` out 1: one-cycle pulse; the stop bit was sampled low.
- `o_Parity_Err` out 1: one-cycle pulse; parity mismatch (only with the macro defined).
- `o_Busy` out 1: high in any state other than IDLE.

## Operation
- Two-flop synchronizer on `i_Rx_Serial`. Both flops reset to 1. All logic uses the synchronized line `s_rx`.
- Bit counter is `$clog2(CLKS_PER_BIT)` bits wide. Bit index is 3 bits. Data goes into an 8-bit shift register, LSB first.
- Notation: H = CLKS_PER_BIT/2 (integer division), N = CLKS_PER_BIT.
- States:
  - IDLE: when `s_rx`=0, go to START and clear the counter.
  - START: count up. At count H-1:
    - if `s_rx`=0, go to DATA with counter 0 and bit index 0;
    - else treat it as a glitch and return to IDLE with no outputs.
  - DATA: at count N-1, shift in `s_rx` and clear the counter. After bit index 7, go to PARITY if the macro is defined, otherwise STOP.
  - PARITY: at count N-1, sample the parity bit and go to STOP.
  - STOP: at count N-1, sample `s_rx`.
    - If 1 and parity is OK: load `o_Rx_Byte` and pulse `o_Rx_DV`.
    - If 0: pulse `o_Frame_Err`; no DV, and `o_Rx_Byte` is unchanged.
    - In both cases, return to IDLE on the same edge. This leaves half a bit of margin for the next start edge.
- Parity error and frame error on the same frame: both strobes pulse in the same cycle, with no DV.
- A line held low (break) produces a frame error, then the block waits in IDLE → START cycles. It never emits DV until a high stop bit is seen.
- Reset asserted mid-frame: immediately abort to IDLE. The partial byte is discarded and no strobe is issued.

## Timing
- Reset values:
  - `o_Rx_DV`=0, `o_Rx_Byte`=8'h00, `o_Frame_Err`=0, `o_Parity_Err`=0, `o_Busy`=0;
  - state IDLE, counters 0, synchronizer flops 1.
- Strobes are registered and high for exactly one cycle.
- Latency: let P be the first rising edge that samples the pin low at the start bit.
  - IDLE→START at edge P+2.
  - `o_Rx_DV` is high in the cycle after edge P+2+H+9N (8N1), or P+2+H+10N with parity.
- Back-to-back frames with no idle gap are received without loss.
- Tolerated baud mismatch: ±2 % cumulative.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the PARITY state exists;
  - even parity, so the XOR of the 8 data bits and the parity bit must equal 0;
  - on mismatch, pulse `o_Parity_Err` at the stop-bit sample and suppress DV.
- `UART_RX_PARITY_EN` undefined:
  - no PARITY state;
  - `o_Parity_Err` tied to 0;
  - frame format is 8N1.

## Structure
- Package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP) as a 3-bit typedef;
  - constants `UART_DATA_BITS`=8 and `UART_IDLE_LEVEL`=1'b1.
- One sub-module, `bit_synchronizer`: a 2-flop synchronizer with a reset value parameter.

## Test plan
Bench uses `CLKS_PER_BIT`=16.
- Frame 0xA5, 8N1 → single `o_Rx_DV` pulse; `o_Rx_Byte`=8'hA5 at P+2+8+144; `o_Busy` low afterwards.
- Back-to-back 0x00 then 0xFF with no idle gap → two DV pulses 160 cycles apart; bytes 8'h00 then 8'hFF.
- 4-cycle low glitch on an idle line → returns to IDLE; no DV and no error strobes.
- 0x3C sent with stop bit low → one `o_Frame_Err` pulse, no DV; `o_Rx_Byte` keeps its previous value.
- Reset pulsed low mid-DATA during 0x81, then a full 0x42 frame sent → all outputs at reset values during reset; only one DV, with byte 8'h42.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 → `o_Parity_Err` pulse, no DV. The same byte with parity bit 1 → DV with byte 8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg: shared state encoding and frame constants for uart_receiver |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_receiver_if.sv
// +----------------------------------------------------------------------+
// | uart_receiver_if: received-byte strobes and status from uart_receiver |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface uart_receiver_if;
   import uart_pkg::*;

   logic                      o_Rx_DV;
   logic [UART_DATA_BITS-1:0] o_Rx_Byte;
   logic                      o_Frame_Err;
   logic                      o_Parity_Err;
   logic                      o_Busy;

   modport master (
      output o_Rx_DV,
      output o_Rx_Byte,
      output o_Frame_Err,
      output o_Parity_Err,
      output o_Busy
   );

   modport slave (
      input  o_Rx_DV,
      input  o_Rx_Byte,
      input  o_Frame_Err,
      input  o_Parity_Err,
      input  o_Busy
   );
endinterface

`default_nettype wire

// File: rtl/bit_synchronizer.sv
// +----------------------------------------------------------------------+
// | bit_synchronizer: two-flop synchronizer with configurable reset value |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bit_synchronizer #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// +----------------------------------------------------------------------+
// | uart_receiver: 8N1 UART byte receiver; 8E1 when UART_RX_PARITY_EN is  |
// | defined. Rev 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic            i_Clock,
   input  logic            i_Reset_n,
   input  logic            i_Rx_Serial,
   uart_receiver_if.master rx_if
);

   localparam int                CNT_W       = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
   localparam logic [2:0]        C_LAST_IDX  = 3'(UART_DATA_BITS - 1);

   logic                      s_rx;
   uart_state_e               state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [2:0]                idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [UART_DATA_BITS-1:0] byte_q;
   logic                      dv_q;
   logic                      ferr_q;
   logic                      busy_q;
`ifdef UART_RX_PARITY_EN
   logic                      perr_q;
   logic                      par_ok_q;
`endif

   bit_synchronizer #(
      .RESET_VAL (UART_IDLE_LEVEL)
   ) u_rx_sync (
      .clk_i  (i_Clock),
      .rst_ni (i_Reset_n),
      .d_i    (i_Rx_Serial),
      .q_o    (s_rx)
   );

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         byte_q   <= '0;
         dv_q     <= 1'b0;
         ferr_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q   <= 1'b0;
         par_ok_q <= 1'b1;
`endif
      end else begin
         dv_q   <= 1'b0;
         ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (s_rx != UART_IDLE_LEVEL) begin
                  state_q <= ST_START;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end

            // Re-check the line mid start bit to reject short glitches.
            ST_START: begin
               if (cnt_q == C_HALF_LAST) begin
                  cnt_q <= '0;
                  if (s_rx == 1'b0) begin
                     state_q <= ST_DATA;
                     idx_q   <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + C_CNT_ONE;
               end
            end

            ST_DATA: begin
               if (cnt_q == C_BIT_LAST) begin
                  cnt_q   <= '0;
                  shift_q <= {s_rx, shift_q[UART_DATA_BITS-1:1]};
                  if (idx_q == C_LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + C_CNT_ONE;
               end
            end

`ifdef UART_RX_PARITY_EN
            // Even parity: data bits XOR parity bit must be zero.
            ST_PARITY: begin
               if (cnt_q == C_BIT_LAST) begin
                  cnt_q    <= '0;
                  par_ok_q <= ~((^shift_q) ^ s_rx);
                  state_q  <= ST_STOP;
               end else begin
                  cnt_q <= cnt_q + C_CNT_ONE;
               end
            end
`endif

            ST_STOP: begin
               if (cnt_q == C_BIT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                  perr_q  <= ~par_ok_q;
                  if (s_rx && par_ok_q) begin
`else
                  if (s_rx) begin
`endif
                     byte_q <= shift_q;
                     dv_q   <= 1'b1;
                  end
                  if (!s_rx) begin
                     ferr_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + C_CNT_ONE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_if.o_Rx_DV     = dv_q;
   assign rx_if.o_Rx_Byte   = byte_q;
   assign rx_if.o_Frame_Err = ferr_q;
   assign rx_if.o_Busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.o_Parity_Err = perr_q;
`else
   assign rx_if.o_Parity_Err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// +----------------------------------------------------------------------+
// | tb_uart_receiver: directed frames against a cycle-indexed frame model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_receiver;
   import uart_pkg::*;

   localparam int N    = 16;
   localparam int H    = N / 2;
   localparam int MAXC = 4096;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
   localparam int FBITS  = 11;
   localparam int LAT    = 170;
`else
   localparam bit PAR_EN = 1'b0;
   localparam int FBITS  = 10;
   localparam int LAT    = 154;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic pin   = 1'b1;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   uart_receiver_if rx_if ();

   uart_receiver #(
      .CLKS_PER_BIT (N)
   ) dut (
      .i_Clock     (clk),
      .i_Reset_n   (rst_n),
      .i_Rx_Serial (pin),
      .rx_if       (rx_if)
   );

   // Expected outputs indexed by the rising edge after which they appear.
   bit         dv_map   [MAXC];
   bit         fe_map   [MAXC];
   bit         pe_map   [MAXC];
   bit         busy_map [MAXC];
   bit         bu_valid [MAXC];
   logic [7:0] bu_val   [MAXC];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 50)
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   logic [7:0] model_byte = 8'h00;
   int         dv_seen = 0;
   int         fe_seen = 0;
   int         pe_seen = 0;
   int         dv_cyc[$];
   logic [7:0] dv_bytes[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         model_byte = 8'h00;
         chk("rst_dv",   32'(rx_if.o_Rx_DV),      32'd0);
         chk("rst_byte", 32'(rx_if.o_Rx_Byte),    32'd0);
         chk("rst_fe",   32'(rx_if.o_Frame_Err),  32'd0);
         chk("rst_pe",   32'(rx_if.o_Parity_Err), 32'd0);
         chk("rst_busy", 32'(rx_if.o_Busy),       32'd0);
      end else begin
         if (bu_valid[cyc]) model_byte = bu_val[cyc];
         chk("dv",   32'(rx_if.o_Rx_DV),      32'(dv_map[cyc]));
         chk("byte", 32'(rx_if.o_Rx_Byte),    32'(model_byte));
         chk("fe",   32'(rx_if.o_Frame_Err),  32'(fe_map[cyc]));
         chk("pe",   32'(rx_if.o_Parity_Err), 32'(pe_map[cyc]));
         chk("busy", 32'(rx_if.o_Busy),       32'(busy_map[cyc]));
      end
      if (rx_if.o_Rx_DV === 1'b1) begin
         dv_seen++;
         dv_cyc.push_back(cyc);
         dv_bytes.push_back(rx_if.o_Rx_Byte);
      end
      if (rx_if.o_Frame_Err === 1'b1)  fe_seen++;
      if (rx_if.o_Parity_Err === 1'b1) pe_seen++;
   end

   // Frame rules: the stop bit is judged half a bit after the start edge plus
   // the data (and parity) bits; a low stop bit leaves the line low long enough
   // to re-arm the receiver, which then rejects it as a glitch.
   task automatic schedule_frame(input int p, input logic [7:0] d, input bit par_bit, input bit stop);
      int e;
      bit par_ok;
      e      = p + 2 + H + (FBITS - 1) * N;
      par_ok = (((^d) ^ par_bit) == 1'b0) || !PAR_EN;
      for (int c = p + 2; c < e; c++) busy_map[c] = 1'b1;
      pe_map[e] = !par_ok;
      fe_map[e] = !stop;
      if (stop && par_ok) begin
         dv_map[e]   = 1'b1;
         bu_valid[e] = 1'b1;
         bu_val[e]   = d;
      end
      if (!stop)
         for (int c = e + 1; c < e + 1 + H; c++) busy_map[c] = 1'b1;
   endtask

   // Entered and left just after a rising edge.
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit par_bit, input bit stop,
                             input int abort_bits, output int p);
      bit bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (PAR_EN) bits.push_back(par_bit);
      bits.push_back(stop);
      p = cyc + 1;
      schedule_frame(p, d, par_bit, stop);
      for (int i = 0; i < bits.size(); i++) begin
         if (abort_bits != 0 && i == abort_bits) return;
         pin = bits[i];
         repeat (N) @(posedge clk);
         #1;
      end
      pin = 1'b1;
   endtask

   task automatic send_glitch(input int low_cycles);
      int p;
      p = cyc + 1;
      for (int c = p + 2; c < p + 2 + H; c++) busy_map[c] = 1'b1;
      pin = 1'b0;
      repeat (low_cycles) @(posedge clk);
      #1;
      pin = 1'b1;
   endtask

   task automatic reset_pulse(input int hold);
      rst_n = 1'b0;
      pin   = 1'b1;
      for (int c = cyc; c < MAXC; c++) begin
         dv_map[c] = 1'b0; fe_map[c] = 1'b0; pe_map[c] = 1'b0;
         busy_map[c] = 1'b0; bu_valid[c] = 1'b0;
      end
      #2;
      chk("midreset_byte", 32'(rx_if.o_Rx_Byte), 32'h00);
      chk("midreset_busy", 32'(rx_if.o_Busy),    32'd0);
      chk("midreset_dv",   32'(rx_if.o_Rx_DV),   32'd0);
      repeat (hold) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int p_a5, p0, p1, p_fe, p_abort, p42, p_bad, p_good;
      repeat (3) @(posedge clk);
      #1;
      chk("init_dv",   32'(rx_if.o_Rx_DV),      32'd0);
      chk("init_byte", 32'(rx_if.o_Rx_Byte),    32'h00);
      chk("init_fe",   32'(rx_if.o_Frame_Err),  32'd0);
      chk("init_pe",   32'(rx_if.o_Parity_Err), 32'd0);
      chk("init_busy", 32'(rx_if.o_Busy),       32'd0);
      rst_n = 1'b1;
      idle(5);

      // 0xA5 (four ones: even parity bit 0)
      send_frame(8'hA5, 1'b0, 1'b1, 0, p_a5);
      idle(40);
      chk("a5_count", 32'(dv_seen), 32'd1);
      if (dv_seen >= 1) chk("a5_latency", 32'(dv_cyc[0] - p_a5), 32'(LAT));
      chk("a5_byte", 32'(rx_if.o_Rx_Byte), 32'hA5);
      chk("a5_busy_after", 32'(rx_if.o_Busy), 32'd0);

      // back-to-back 0x00, 0xFF
      send_frame(8'h00, 1'b0, 1'b1, 0, p0);
      send_frame(8'hFF, 1'b0, 1'b1, 0, p1);
      idle(40);
      chk("b2b_count", 32'(dv_seen), 32'd3);
      if (dv_seen >= 3) begin
         chk("b2b_spacing", 32'(dv_cyc[2] - dv_cyc[1]), 32'(FBITS * N));
         chk("b2b_byte0",   32'(dv_bytes[1]), 32'h00);
         chk("b2b_byte1",   32'(dv_bytes[2]), 32'hFF);
      end

      send_glitch(4);
      idle(40);
      chk("glitch_dv", 32'(dv_seen), 32'd3);
      chk("glitch_fe", 32'(fe_seen), 32'd0);
      chk("glitch_pe", 32'(pe_seen), 32'd0);

      // 0x3C with a low stop bit
      send_frame(8'h3C, 1'b0, 1'b0, 0, p_fe);
      idle(40);
      chk("fe_count", 32'(fe_seen), 32'd1);
      chk("fe_no_dv", 32'(dv_seen), 32'd3);
      chk("fe_byte_kept", 32'(rx_if.o_Rx_Byte), 32'hFF);

      // 0x81 aborted by reset after start + three data bits, then 0x42
      send_frame(8'h81, 1'b0, 1'b1, 4, p_abort);
      reset_pulse(4);
      idle(10);
      send_frame(8'h42, 1'b0, 1'b1, 0, p42);
      idle(40);
      chk("rst_dv_count", 32'(dv_seen), 32'd4);
      if (dv_seen >= 4) chk("rst_byte42", 32'(dv_bytes[3]), 32'h42);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: parity bit 1 is even, 0 is a mismatch
      send_frame(8'h07, 1'b0, 1'b1, 0, p_bad);
      idle(40);
      chk("par_bad_pe", 32'(pe_seen), 32'd1);
      chk("par_bad_no_dv", 32'(dv_seen), 32'd4);
      send_frame(8'h07, 1'b1, 1'b1, 0, p_good);
      idle(40);
      chk("par_good_dv", 32'(dv_seen), 32'd5);
      chk("par_good_byte", 32'(rx_if.o_Rx_Byte), 32'h07);
      chk("par_good_pe", 32'(pe_seen), 32'd1);
`else
      p_bad  = 0;
      p_good = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
